// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state width and encodings.
package btn_debounce_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE_LO = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_HI = 2'd1;
  localparam logic [STATE_W-1:0] ST_IDLE_HI = 2'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_LO = 2'd3;

endpackage

// File: rtl/btn_debounce_if.sv
// Button-side bundle: raw input in, debounced level and strobes out.
// press_cnt is present only when PRESS_CNT_EN is defined.
interface btn_debounce_if;

  logic       btn_in;
  logic       btn_level;
  logic       btn_rise;
  logic       btn_fall;
`ifdef PRESS_CNT_EN
  logic [7:0] press_cnt;

  modport master (output btn_in, input btn_level, btn_rise, btn_fall, press_cnt);
  modport slave  (input btn_in, output btn_level, btn_rise, btn_fall, press_cnt);
`else
  modport master (output btn_in, input btn_level, btn_rise, btn_fall);
  modport slave  (input btn_in, output btn_level, btn_rise, btn_fall);
`endif

endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; no logic between the flops.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: synchronizes btn_in, qualifies each level change over
// STABLE_CYCLES samples, emits registered level/rise/fall (+ press_cnt with PRESS_CNT_EN).
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE_LO | output low, waiting for a synchronized high
// ST_WAIT_HI | counting consecutive high samples before going high
// ST_IDLE_HI | output high, waiting for a synchronized low
// ST_WAIT_LO | counting consecutive low samples before going low
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic               s2;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cnt;
  logic               level_q;
  logic               rise_q;
  logic               fall_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (s2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE_LO;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        ST_IDLE_LO: begin
          if (s2) begin
            state <= ST_WAIT_HI;
            cnt   <= '0;
          end
        end
        ST_WAIT_HI: begin
          if (!s2) begin
            state <= ST_IDLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_IDLE_HI;
            cnt     <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_IDLE_HI: begin
          if (!s2) begin
            state <= ST_WAIT_LO;
            cnt   <= '0;
          end
        end
        ST_WAIT_LO: begin
          if (s2) begin
            state <= ST_IDLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_IDLE_LO;
            cnt     <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Unreachable with a 2-bit encoding, kept so a corrupted state still lands low.
        default: begin
          state   <= ST_IDLE_LO;
          cnt     <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;

`ifdef PRESS_CNT_EN
  logic [7:0] press_q;

  // Counts on the same edge that raises btn_rise so it always agrees with btn_level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q <= 8'd0;
    end else if (state == ST_WAIT_HI && s2 && cnt == CNT_LAST) begin
      press_q <= press_q + 8'd1;
    end
  end

  assign bus.press_cnt = press_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with a run-length reference model.
module tb_btn_debounce;

  localparam int SC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  btn_debounce_if bif ();

  btn_debounce #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: output flips once SC+1 consecutive synchronized samples differ from it.
  bit hist[$];
  bit m_lvl;
  int m_run;
  bit m_rise;
  bit m_fall;
  int m_press;

  int seg_edge;
  int rise_seen;
  int fall_seen;
  int first_rise;
  int first_fall;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_lvl   = 1'b0;
    m_run   = 0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_press = 0;
  endtask

  task automatic new_seg();
    seg_edge   = 0;
    rise_seen  = 0;
    fall_seen  = 0;
    first_rise = 0;
    first_fall = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, int'(bif.btn_level), 0);
    check({tag, "_rise"},  int'(bif.btn_rise),  0);
    check({tag, "_fall"},  int'(bif.btn_fall),  0);
`ifdef PRESS_CNT_EN
    check({tag, "_press"}, int'(bif.press_cnt), 0);
`endif
  endtask

  // Drive b for one clock edge, advance the model, then compare just after the edge.
  task automatic tick(input bit b);
    bit seen;
    bif.btn_in = b;
    @(posedge clk);
    seen = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen != m_lvl) begin
      m_run++;
      if (m_run == SC + 1) begin
        m_lvl = ~m_lvl;
        m_run = 0;
        if (m_lvl) begin
          m_rise  = 1'b1;
          m_press = (m_press + 1) % 256;
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    seg_edge++;
    #1;
    check("level", int'(bif.btn_level), int'(m_lvl));
    check("rise",  int'(bif.btn_rise),  int'(m_rise));
    check("fall",  int'(bif.btn_fall),  int'(m_fall));
`ifdef PRESS_CNT_EN
    check("press_cnt", int'(bif.press_cnt), m_press);
`endif
    if (bif.btn_rise === 1'b1) begin
      rise_seen++;
      if (first_rise == 0) first_rise = seg_edge;
    end
    if (bif.btn_fall === 1'b1) begin
      fall_seen++;
      if (first_fall == 0) first_fall = seg_edge;
    end
  endtask

  // Asynchronous assert at the current time, hold 3 edges, release on a falling edge.
  task automatic do_reset(input bit b);
    rst        = 1'b1;
    bif.btn_in = b;
    #1;
    check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    new_seg();
  endtask

  initial begin
    bit b;
    int len;

    bif.btn_in = 1'b1;
    model_reset();
    new_seg();
    #2;

    // Reset with button held high, then requalify after release.
    do_reset(1'b1);
    repeat (10) tick(1'b1);
    check("rst_rel_rise_edge", first_rise, 7);
    check("rst_rel_rise_cnt", rise_seen, 1);

    // Release from high.
    new_seg();
    repeat (10) tick(1'b0);
    check("release_fall_edge", first_fall, 7);
    check("release_fall_cnt", fall_seen, 1);
    check("release_no_rise", rise_seen, 0);

    // Clean press.
    new_seg();
    repeat (20) tick(1'b1);
    check("press_rise_edge", first_rise, 7);
    check("press_rise_cnt", rise_seen, 1);
    check("press_no_fall", fall_seen, 0);
    check("press_level", int'(bif.btn_level), 1);
    repeat (10) tick(1'b0);

    // Bounce then hold: final 0->1 sampled on edge 5, rise expected on edge 11.
    new_seg();
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
    repeat (15) tick(1'b1);
    check("bounce_rise_edge", first_rise, 11);
    check("bounce_rise_cnt", rise_seen, 1);
    repeat (10) tick(1'b0);

    // Pulse of SC samples must be swallowed.
    new_seg();
    repeat (SC) tick(1'b1);
    repeat (10) tick(1'b0);
    check("short_no_rise", rise_seen, 0);
    check("short_no_fall", fall_seen, 0);
    check("short_level", int'(bif.btn_level), 0);

    // Random hold lengths around the qualification window.
    repeat (80) begin
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      repeat (len) tick(b);
    end

    // Mid-operation reset while high, button kept high through release.
    repeat (10) tick(1'b1);
    check("pre_rst_level", int'(bif.btn_level), 1);
    #2;
    do_reset(1'b1);
    repeat (10) tick(1'b1);
    check("mid_rst_rise_edge", first_rise, 7);
    check("mid_rst_rise_cnt", rise_seen, 1);

`ifdef PRESS_CNT_EN
    do_reset(1'b0);
    repeat (257) begin
      repeat (6) tick(1'b1);
      repeat (6) tick(1'b0);
    end
    check("press_wrap", int'(bif.press_cnt), 1);
    repeat (3) begin
      repeat (6) tick(1'b1);
      repeat (6) tick(1'b0);
    end
    check("press_pre_rst", int'(bif.press_cnt), 4);
    #2;
    do_reset(1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Debounces and synchronizes one raw mechanical pushbutton or switch input. Produces a clean level plus single-cycle rise/fall strobes.
- Sits directly downstream of the board reset synchronizer. Its rst is that synchronizer's deasserting output.
- Its strobes feed the project's control FSMs (mode select, step, clear).

Parameters:
- STABLE_CYCLES, 500000, consecutive synchronized samples at the new level required before the output level changes (5 ms at 100 MHz). Must be >= 2.
- CNT_W, 20, counter width. Must satisfy 2**CNT_W >= STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- btn_in  input  1  raw asynchronous button, active-high, bouncing
- btn_level  output  1  debounced level
- btn_rise  output  1  one-cycle strobe on 0->1 of btn_level
- btn_fall  output  1  one-cycle strobe on 1->0 of btn_level
- press_cnt  output  8  debounced press count (present only with PRESS_CNT_EN)

Behaviour:
- Input path: two-flop synchronizer s1 -> s2. No logic between the flops. s1 and s2 reset to 0.
- FSM states, 2-bit encoding:
  - IDLE_LO (reset state)
  - WAIT_HI
  - IDLE_HI
  - WAIT_LO
- Counter cnt (CNT_W bits), reset 0. Cleared on every entry to a WAIT state.
- IDLE_LO: if s2=1, go to WAIT_HI with cnt=0. Otherwise stay.
- WAIT_HI:
  - If s2=0, return to IDLE_LO (bounce rejected), cnt=0, no strobe.
  - Else if cnt=STABLE_CYCLES-1, go to IDLE_HI; btn_level<=1; btn_rise<=1 for one cycle.
  - Else cnt<=cnt+1.
- IDLE_HI / WAIT_LO: mirror image of the above, with btn_fall.
- All outputs are registered. Reset values: btn_level=0, btn_rise=0, btn_fall=0, press_cnt=0.
- Latency: with btn_in held steady at the new level, btn_level changes on the (STABLE_CYCLES+3)th rising edge, counting the first edge that samples the new value as edge 1. The strobe asserts on the same edge.
- Any glitch back to the old level during WAIT restarts qualification from scratch. Pulses shorter than STABLE_CYCLES+1 synchronized samples never reach the outputs.
- btn_rise and btn_fall are mutually exclusive and never asserted in consecutive cycles.
- cnt never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Reset mid-operation: asserting rst at any point forces IDLE_LO and all outputs to 0 immediately (asynchronously). If btn_in is held high through reset release, the block requalifies and emits btn_rise.
- Undefined state encodings recover to IDLE_LO.

Optional Feature:
- Macro: PRESS_CNT_EN.
- Defined:
  - press_cnt port exists.
  - 8-bit register increments on each btn_rise cycle, wraps 255->0.
  - Reset 0.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state constants (ST_IDLE_LO, ST_WAIT_HI, ST_IDLE_HI, ST_WAIT_LO) and the 2-bit state width.
- Natural sub-module: sync_2ff (parameterless two-flop synchronizer, ports clk, rst, d, q). Reusable by other input blocks.

Test Plan (STABLE_CYCLES=4, CNT_W=3):
- Reset check: rst=1 for 3 cycles with btn_in=1 -> all outputs 0. Release rst with btn_in held at 1 -> btn_level=1 and btn_rise=1 on edge 7 after release, btn_rise=0 on edge 8.
- Clean press: btn_in 0->1 held 20 cycles -> exactly one btn_rise pulse, on edge 7. btn_level stays 1; btn_fall never asserts.
- Bounce rejection: btn_in toggles 1,0,1,0,1 each cycle, then holds 1 -> no strobe during bouncing. Single btn_rise 7 edges after the final 0->1.
- Short pulse: btn_in=1 for 4 cycles, then 0 -> btn_level stays 0, no strobes.
- Release: from btn_level=1, btn_in->0 held -> btn_fall on edge 7, btn_level=0 on the same edge.
- PRESS_CNT_EN: 257 clean presses -> press_cnt=1 after the last one (wrap check). Mid-count rst -> press_cnt=0 immediately.
